// File: rtl/lcd_cmd_sched.sv
// lcd_cmd_sched: toggle-triggered command FIFO feeding a clipped pixel/rectangle rasteriser
// that streams framebuffer writes over a valid/ready port.
module lcd_cmd_sched #(
    parameter int FIFO_DEPTH = 8,
    parameter int H_ACTIVE   = 1280,
    parameter int V_ACTIVE   = 720
) (
    input  logic                          HCLK,
    input  logic                          HRESET,
    input  logic                          LCD_CMD_SIG,
    input  logic [31:0]                   LCD_CMD,
    output logic                          PIX_VALID,
    input  logic                          PIX_READY,
    output logic [11:0]                   PIX_X,
    output logic [11:0]                   PIX_Y,
    output logic [23:0]                   PIX_COLOR,
    output logic                          BUSY,
    output logic                          OVERFLOW,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [3:0] OP_COLOR = 4'h1, OP_POS = 4'h2, OP_FILL = 4'h3, OP_PIXEL = 4'h4;

    typedef enum logic [1:0] {IDLE, EXEC, DRAW} state_t;
    state_t state, state_nx;

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [31:0]   cmd;
    logic          sig_d, push, full, wr, pop, exec, draw_op, gen, slot_free;
    logic          last_x, last, in_range, done;
    logic [3:0]    op;
    logic [11:0]   ca, cb, x0, y0, bx, by, w, h, ix, iy;
    logic [11:0]   g_bx, g_by, g_w, g_h, g_ix, g_iy;
    logic [23:0]   color, col_l, g_col;
    logic [12:0]   gx, gy;
    logic          unused_bits;

    assign op          = cmd[31:28];
    assign ca          = cmd[23:12];
    assign cb          = cmd[11:0];
    assign unused_bits = ^cmd[27:24];
    assign push        = LCD_CMD_SIG ^ sig_d;
    assign full        = FIFO_LEVEL == LW'(FIFO_DEPTH);
    assign wr          = push & ~full;

    always_ff @(posedge HCLK or posedge HRESET)
        if (HRESET) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = state == IDLE ? (pop ? EXEC : IDLE)
                 : state == EXEC ? (draw_op ? DRAW : IDLE)
                 : (done & slot_free ? IDLE : DRAW);
    end

    // The first pixel of a draw is generated straight from the command during EXEC,
    // so the generator selects between command fields and the latched draw context.
    always_comb begin
        exec      = state == EXEC;
        draw_op   = exec & ((op == OP_FILL & |ca & |cb) | op == OP_PIXEL);
        pop       = state == IDLE & |FIFO_LEVEL;
        BUSY      = state != IDLE | |FIFO_LEVEL;
        slot_free = ~PIX_VALID | PIX_READY;
        gen       = slot_free & (draw_op | (state == DRAW & ~done));
        g_bx      = exec ? (op == OP_PIXEL ? ca : x0) : bx;
        g_by      = exec ? (op == OP_PIXEL ? cb : y0) : by;
        g_w       = exec ? (op == OP_PIXEL ? 12'd1 : ca) : w;
        g_h       = exec ? (op == OP_PIXEL ? 12'd1 : cb) : h;
        g_ix      = exec ? 12'd0 : ix;
        g_iy      = exec ? 12'd0 : iy;
        g_col     = exec ? color : col_l;
        gx        = {1'b0, g_bx} + {1'b0, g_ix};
        gy        = {1'b0, g_by} + {1'b0, g_iy};
        in_range  = gx < 13'(H_ACTIVE) & gy < 13'(V_ACTIVE);
        last_x    = g_ix == g_w - 12'd1;
        last      = last_x & g_iy == g_h - 12'd1;
    end

    always_ff @(posedge HCLK)
        if (wr) mem[wp] <= LCD_CMD;

    always_ff @(posedge HCLK or posedge HRESET)
        if (HRESET) begin
            sig_d      <= 1'b0;
            wp         <= '0;
            rp         <= '0;
            cmd        <= '0;
            FIFO_LEVEL <= '0;
            OVERFLOW   <= 1'b0;
            color      <= '0;
            x0         <= '0;
            y0         <= '0;
            bx         <= '0;
            by         <= '0;
            w          <= '0;
            h          <= '0;
            col_l      <= '0;
            ix         <= '0;
            iy         <= '0;
            done       <= 1'b0;
            PIX_VALID  <= 1'b0;
            PIX_X      <= '0;
            PIX_Y      <= '0;
            PIX_COLOR  <= '0;
        end else begin
            sig_d      <= LCD_CMD_SIG;
            FIFO_LEVEL <= FIFO_LEVEL + LW'(wr) - LW'(pop);
            if (wr) wp <= wp + 1'b1;
            if (pop) begin
                rp  <= rp + 1'b1;
                cmd <= mem[rp];
            end
            if (push & full) OVERFLOW <= 1'b1;
            if (exec & op == OP_COLOR) color <= cmd[23:0];
            if (exec & op == OP_POS) begin
                x0 <= ca;
                y0 <= cb;
            end
            if (draw_op) begin
                bx    <= g_bx;
                by    <= g_by;
                w     <= g_w;
                h     <= g_h;
                col_l <= color;
            end
            if (gen) begin
                ix   <= last_x ? 12'd0 : g_ix + 12'd1;
                iy   <= last_x ? g_iy + 12'd1 : g_iy;
                done <= last;
            end
            // Clipped pixels consume a generate slot but never raise PIX_VALID.
            PIX_VALID <= gen ? in_range : PIX_VALID & ~PIX_READY;
            if (gen & in_range) begin
                PIX_X     <= gx[11:0];
                PIX_Y     <= gy[11:0];
                PIX_COLOR <= g_col;
            end
        end
endmodule

// File: tb/tb_lcd_cmd_sched.sv
// tb_lcd_cmd_sched: scoreboard of expected pixels built from command semantics, plus
// directed timing/overflow/reset sequences and randomized command bursts.
module tb_lcd_cmd_sched;
    logic        HCLK = 1'b0, HRESET = 1'b1, LCD_CMD_SIG = 1'b0, PIX_READY = 1'b0;
    logic [31:0] LCD_CMD = '0;
    logic        PIX_VALID, BUSY, OVERFLOW;
    logic [11:0] PIX_X, PIX_Y;
    logic [23:0] PIX_COLOR;
    logic [3:0]  FIFO_LEVEL;

    lcd_cmd_sched dut (
        .HCLK(HCLK), .HRESET(HRESET), .LCD_CMD_SIG(LCD_CMD_SIG), .LCD_CMD(LCD_CMD),
        .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY), .PIX_X(PIX_X), .PIX_Y(PIX_Y),
        .PIX_COLOR(PIX_COLOR), .BUSY(BUSY), .OVERFLOW(OVERFLOW), .FIFO_LEVEL(FIFO_LEVEL)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [31:0] cmd;
        int          npix;
    } vec_t;

    int          tests = 0, fails = 0, hs_count = 0, hs0;
    logic [47:0] exp_q[$];
    logic [23:0] m_color = '0;
    logic [11:0] m_x0 = '0, m_y0 = '0;
    bit          rnd_ready = 0;
    vec_t        tbl[15];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] got);
        tests++;
        fails++;
        $display("FAIL %s: got %0h expected none", name, got);
    endtask

    // Reference: each accepted command is expanded into its visible pixels in issue order.
    task automatic model(input logic [31:0] c);
        logic [11:0] a, b;
        a = c[23:12];
        b = c[11:0];
        case (c[31:28])
            4'h1: m_color = c[23:0];
            4'h2: begin m_x0 = a; m_y0 = b; end
            4'h3: for (int j = 0; j < int'(b); j++)
                      for (int i = 0; i < int'(a); i++)
                          if (int'(m_x0) + i < 1280 && int'(m_y0) + j < 720)
                              exp_q.push_back({12'(int'(m_x0) + i), 12'(int'(m_y0) + j), m_color});
            4'h4: if (a < 12'd1280 && b < 12'd720) exp_q.push_back({a, b, m_color});
            default: ;
        endcase
    endtask

    task automatic model_reset();
        m_color = '0;
        m_x0 = '0;
        m_y0 = '0;
        exp_q.delete();
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
        if (rnd_ready) PIX_READY = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [31:0] c, input bit acc);
        LCD_CMD = c;
        LCD_CMD_SIG = ~LCD_CMD_SIG;
        if (acc) model(c);
        step();
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((BUSY || PIX_VALID) && n < 3000) begin step(); n++; end
        if (n >= 3000) fail_now("idle timeout", {63'd0, BUSY});
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!PIX_VALID && n < 100) begin step(); n++; end
        if (n >= 100) fail_now("valid timeout", {63'd0, PIX_VALID});
    endtask

    function automatic logic [31:0] rand_cmd();
        int sel = $urandom_range(0, 9);
        logic [11:0] a, b;
        if (sel < 2) return {8'h10, 24'($urandom)};
        if (sel < 4) begin
            a = $urandom_range(0, 1) ? 12'($urandom_range(0, 20)) : 12'($urandom_range(1270, 1285));
            b = $urandom_range(0, 1) ? 12'($urandom_range(0, 20)) : 12'($urandom_range(710, 725));
            return {8'h20, a, b};
        end
        if (sel < 7) return {8'h30, 12'($urandom_range(0, 4)), 12'($urandom_range(0, 4))};
        if (sel < 9) begin
            a = $urandom_range(0, 1) ? 12'($urandom_range(0, 10)) : 12'($urandom_range(1275, 1284));
            b = 12'($urandom_range(715, 724));
            return {8'h40, a, b};
        end
        return {4'($urandom_range(5, 15)), 28'($urandom)};
    endfunction

    // Pixel monitor: every handshake must match the next expected pixel; stalled outputs must hold.
    logic        stall = 1'b0;
    logic [47:0] held;
    always @(negedge HCLK) begin
        if (HRESET) stall = 1'b0;
        else begin
            if (stall) chk("hold stable", {PIX_VALID, PIX_X, PIX_Y, PIX_COLOR}, {1'b1, held});
            if (PIX_VALID && PIX_READY) begin
                hs_count++;
                if (exp_q.size() == 0) fail_now("unexpected pixel", {PIX_X, PIX_Y, PIX_COLOR});
                else chk("pixel", {PIX_X, PIX_Y, PIX_COLOR}, exp_q.pop_front());
            end
            stall = PIX_VALID && !PIX_READY;
            held = {PIX_X, PIX_Y, PIX_COLOR};
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{32'h10ABCDEF, 0};
        tbl[1]  = '{32'h200640C8, 0};
        tbl[2]  = '{32'h30002002, 4};
        tbl[3]  = '{32'h30000005, 0};
        tbl[4]  = '{32'hF0012345, 0};
        tbl[5]  = '{32'h40001001, 1};
        tbl[6]  = '{32'h30002002, 4};
        tbl[7]  = '{32'h404FF2CF, 1};
        tbl[8]  = '{32'h40500000, 0};
        tbl[9]  = '{32'h400002D0, 0};
        tbl[10] = '{32'h00000000, 0};
        tbl[11] = '{32'h2FFFFFFF, 0};
        tbl[12] = '{32'h30002002, 0};
        tbl[13] = '{32'h204FF000, 0};
        tbl[14] = '{32'h30003001, 1};

        #1;
        step();
        step();
        HRESET = 1'b0;
        chk("rst valid", PIX_VALID, 0);
        chk("rst x", PIX_X, 0);
        chk("rst y", PIX_Y, 0);
        chk("rst color", PIX_COLOR, 0);
        chk("rst busy", BUSY, 0);
        chk("rst overflow", OVERFLOW, 0);
        chk("rst level", FIFO_LEVEL, 0);

        // Basic fill with exact first-pixel latency
        PIX_READY = 1'b1;
        send(32'h10FF0000, 1);
        send(32'h2000A014, 1);
        wait_idle();
        hs0 = hs_count;
        send(32'h30003002, 1);
        chk("fill valid N+1", PIX_VALID, 0);
        step();
        chk("fill valid N+2", PIX_VALID, 0);
        step();
        chk("fill valid N+3", PIX_VALID, 1);
        chk("fill first xy", {PIX_X, PIX_Y}, {12'd10, 12'd20});
        chk("fill color", PIX_COLOR, 24'hFF0000);
        wait_idle();
        chk("fill count", hs_count - hs0, 6);
        chk("fill busy low", BUSY, 0);

        // Backpressured single pixel
        PIX_READY = 1'b0;
        hs0 = hs_count;
        send(32'h40005007, 1);
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            chk("stall valid", PIX_VALID, 1);
            chk("stall xyc", {PIX_X, PIX_Y, PIX_COLOR}, {12'd5, 12'd7, 24'hFF0000});
            if (i < 3) step();
        end
        PIX_READY = 1'b1;
        step();
        PIX_READY = 1'b0;
        chk("pixel released", PIX_VALID, 0);
        step();
        chk("pixel once", hs_count - hs0, 1);
        PIX_READY = 1'b1;
        wait_idle();

        // Clipping at the bottom-right corner
        hs0 = hs_count;
        send(32'h204FE2CF, 1);
        send(32'h30004002, 1);
        wait_idle();
        chk("clip count", hs_count - hs0, 2);

        // Zero-size fill and unknown op back to back
        send(32'h30000005, 1);
        send(32'hF0012345, 1);
        wait_idle();
        chk("noop level", FIFO_LEVEL, 0);

        // Table of single commands with expected pixel counts
        for (int t = 0; t < 15; t++) begin
            hs0 = hs_count;
            send(tbl[t].cmd, 1);
            wait_idle();
            chk($sformatf("table[%0d] count", t), hs_count - hs0, tbl[t].npix);
        end

        // FIFO overflow while a fill is stalled
        PIX_READY = 1'b0;
        hs0 = hs_count;
        send(32'h20000000, 1);
        send(32'h30004004, 1);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            send({8'h40, 12'(i + 1), 12'd50}, i < 8);
            chk($sformatf("ovf level %0d", i), FIFO_LEVEL, (i + 1 > 8) ? 8 : i + 1);
            chk($sformatf("ovf flag %0d", i), OVERFLOW, (i >= 8) ? 1 : 0);
        end
        PIX_READY = 1'b1;
        wait_idle();
        chk("ovf drained count", hs_count - hs0, 24);
        chk("ovf sticky", OVERFLOW, 1);

        // Reset in the middle of a fill with commands queued
        PIX_READY = 1'b0;
        send(32'h30004004, 1);
        wait_valid();
        send(32'h10123456, 1);
        send(32'h40001001, 1);
        send(32'h40002002, 1);
        chk("pre-reset level", FIFO_LEVEL, 3);
        HRESET = 1'b1;
        LCD_CMD_SIG = 1'b0;
        model_reset();
        #1;
        chk("reset drops valid", PIX_VALID, 0);
        chk("reset level", FIFO_LEVEL, 0);
        chk("reset overflow", OVERFLOW, 0);
        step();
        HRESET = 1'b0;
        PIX_READY = 1'b1;
        send(32'h40003003, 1);
        step();
        step();
        chk("post-reset valid", PIX_VALID, 1);
        chk("post-reset color", PIX_COLOR, 0);
        wait_idle();

        // Randomized bursts against the reference model
        rnd_ready = 1;
        for (int b = 0; b < 40; b++) begin
            int n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) send(rand_cmd(), 1);
            wait_idle();
        end
        rnd_ready = 0;
        PIX_READY = 1'b1;
        chk("all pixels seen", exp_q.size(), 0);
        chk("final level", FIFO_LEVEL, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
